// File: rtl/csr_pkg.sv
// Shared CSR address map, op encoding and address classification helper.
package csr_pkg;

  localparam logic [11:0] CSR_TOHOST   = 12'h51E;
  localparam logic [11:0] CSR_CYCLE    = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
  localparam logic [11:0] CSR_INSTRET  = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH = 12'hC82;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'd0,
    CSR_OP_RW   = 2'd1,
    CSR_OP_RS   = 2'd2,
    CSR_OP_RC   = 2'd3
  } csr_op_e;

  function automatic logic csr_is_ro(input logic [11:0] addr);
    return (addr == CSR_CYCLE)   || (addr == CSR_CYCLEH) ||
           (addr == CSR_INSTRET) || (addr == CSR_INSTRETH);
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with enable; wraps silently at 2^64-1.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_en,
  output logic [63:0] o_count
);

  logic [63:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r_count <= '0;
    else if (i_en) r_count <= r_count + 64'd1;
  end

  assign o_count = r_count;

endmodule

// File: rtl/csr_file.sv
// tohost CSR owner with csrrw/csrrs/csrrc execution and pass/fail verdict latch.
// Build option CSR_COUNTERS_EN adds the cycle/instret counters; otherwise they read as 0.
module csr_file
  import csr_pkg::*;
#(
  parameter logic [11:0] TOHOST_ADDR  = CSR_TOHOST,
  parameter logic [31:0] RESET_TOHOST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        csr_en,
  input  logic [1:0]  csr_op,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  input  logic        stall,
  input  logic        instr_retire,
  output logic [31:0] csr_rdata,
  output logic        csr_rvalid,
  output logic        csr_illegal,
  output logic [31:0] tohost,
  output logic        test_done,
  output logic        test_pass
);

  logic [31:0] r_tohost;
  logic [31:0] r_rdata;
  logic        r_rvalid;
  logic        r_illegal;
  logic        r_done;
  logic        r_pass;

  csr_op_e     w_op;
  logic        w_accept;
  logic        w_is_tohost;
  logic        w_is_ro;
  logic        w_wr_req;
  logic        w_illegal;
  logic        w_tohost_we;
  logic [31:0] w_old;
  logic [31:0] w_new;

  assign w_op        = csr_op_e'(csr_op);
  assign w_accept    = csr_en && !stall && (w_op != CSR_OP_NONE);
  assign w_is_tohost = (csr_addr == TOHOST_ADDR);
  assign w_is_ro     = csr_is_ro(csr_addr);
  // Set/clear with a zero mask is a pure read, so it is legal on counters.
  assign w_wr_req    = (w_op == CSR_OP_RW) || (csr_wdata != '0);
  assign w_illegal   = !(w_is_tohost || w_is_ro) || (w_is_ro && w_wr_req);
  assign w_tohost_we = w_accept && w_is_tohost && w_wr_req;

`ifdef CSR_COUNTERS_EN
  logic [63:0] w_cycle;
  logic [63:0] w_instret;

  csr_counter64 u_cycle (
    .clk     (clk),
    .rst     (rst),
    .i_en    (1'b1),
    .o_count (w_cycle)
  );

  csr_counter64 u_instret (
    .clk     (clk),
    .rst     (rst),
    .i_en    (instr_retire && !stall),
    .o_count (w_instret)
  );
`else
  logic w_unused_retire;
  assign w_unused_retire = instr_retire;
`endif

  always_comb begin
    w_old = '0;
`ifdef CSR_COUNTERS_EN
    case (csr_addr)
      CSR_CYCLE:    w_old = w_cycle[31:0];
      CSR_CYCLEH:   w_old = w_cycle[63:32];
      CSR_INSTRET:  w_old = w_instret[31:0];
      CSR_INSTRETH: w_old = w_instret[63:32];
      default:      w_old = '0;
    endcase
`endif
    if (w_is_tohost) w_old = r_tohost;
  end

  always_comb begin
    w_new = w_old;
    case (w_op)
      CSR_OP_RW: w_new = csr_wdata;
      CSR_OP_RS: w_new = w_old | csr_wdata;
      CSR_OP_RC: w_new = w_old & ~csr_wdata;
      default:   w_new = w_old;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tohost  <= RESET_TOHOST;
      r_rdata   <= '0;
      r_rvalid  <= 1'b0;
      r_illegal <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
    end else begin
      r_rvalid  <= w_accept;
      r_illegal <= w_accept && w_illegal;
      if (w_accept) r_rdata <= w_old;
      if (w_tohost_we) r_tohost <= w_new;
      // Only the first done write decides the verdict; it then sticks until reset.
      if (w_tohost_we && !r_done && w_new[0]) begin
        r_done <= 1'b1;
        r_pass <= (w_new[31:1] == '0);
      end
    end
  end

  assign csr_rdata   = r_rdata;
  assign csr_rvalid  = r_rvalid;
  assign csr_illegal = r_illegal;
  assign tohost      = r_tohost;
  assign test_done   = r_done;
  assign test_pass   = r_pass;

endmodule

// File: tb/tb_csr_file.sv
// Directed-vector bench for csr_file; counter expectations follow CSR_COUNTERS_EN.
module tb_csr_file;

`ifdef CSR_COUNTERS_EN
  localparam bit CNT = 1'b1;
`else
  localparam bit CNT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        csr_en = 1'b0;
  logic [1:0]  csr_op = 2'd0;
  logic [11:0] csr_addr = 12'h0;
  logic [31:0] csr_wdata = 32'h0;
  logic        stall = 1'b0;
  logic        instr_retire = 1'b0;
  logic [31:0] csr_rdata;
  logic        csr_rvalid;
  logic        csr_illegal;
  logic [31:0] tohost;
  logic        test_done;
  logic        test_pass;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  csr_file dut (
    .clk          (clk),
    .rst          (rst),
    .csr_en       (csr_en),
    .csr_op       (csr_op),
    .csr_addr     (csr_addr),
    .csr_wdata    (csr_wdata),
    .stall        (stall),
    .instr_retire (instr_retire),
    .csr_rdata    (csr_rdata),
    .csr_rvalid   (csr_rvalid),
    .csr_illegal  (csr_illegal),
    .tohost       (tohost),
    .test_done    (test_done),
    .test_pass    (test_pass)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive one instruction at the negedge, sample registered outputs just after the next posedge.
  task automatic access(input logic [1:0] op, input logic [11:0] addr,
                        input logic [31:0] wdata, input logic st);
    @(negedge clk);
    csr_en = 1'b1; csr_op = op; csr_addr = addr; csr_wdata = wdata; stall = st;
    @(posedge clk);
    #1;
    csr_en = 1'b0; csr_op = 2'd0; stall = 1'b0;
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    #3;
    chk("rst_tohost", tohost, 32'h0);
    chk("rst_rdata", csr_rdata, 32'h0);
    chk("rst_rvalid", {31'h0, csr_rvalid}, 32'h0);
    chk("rst_illegal", {31'h0, csr_illegal}, 32'h0);
    chk("rst_done", {31'h0, test_done}, 32'h0);
    chk("rst_pass", {31'h0, test_pass}, 32'h0);
    repeat (30) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // cycle: 10 edges after release, read returns 10
    repeat (10) @(posedge clk);
    access(2'd2, 12'hC00, 32'h0, 1'b0);
    chk("cyc_rd", csr_rdata, CNT ? 32'd10 : 32'd0);
    chk("cyc_rvalid", {31'h0, csr_rvalid}, 32'h1);
    chk("cyc_rd_ill", {31'h0, csr_illegal}, 32'h0);
    access(2'd1, 12'hC00, 32'hDEAD_0000, 1'b0);
    chk("cyc_wr_ill", {31'h0, csr_illegal}, 32'h1);
    chk("cyc_wr_old", csr_rdata, CNT ? 32'd11 : 32'd0);
    access(2'd2, 12'hC00, 32'h0, 1'b0);
    chk("cyc_after_wr", csr_rdata, CNT ? 32'd12 : 32'd0);
    access(2'd2, 12'hC80, 32'h0, 1'b0);
    chk("cych_rd", csr_rdata, 32'h0);
    access(2'd1, 12'h123, 32'h5, 1'b0);
    chk("unmap_ill", {31'h0, csr_illegal}, 32'h1);
    chk("unmap_rdata", csr_rdata, 32'h0);
    @(posedge clk); #1;
    chk("rvalid_pulse", {31'h0, csr_rvalid}, 32'h0);
    chk("ill_clear", {31'h0, csr_illegal}, 32'h0);

    // Passing verdict
    access(2'd1, 12'h51E, 32'h1, 1'b0);
    chk("pass_rvalid", {31'h0, csr_rvalid}, 32'h1);
    chk("pass_rdata", csr_rdata, 32'h0);
    chk("pass_tohost", tohost, 32'h1);
    chk("pass_done", {31'h0, test_done}, 32'h1);
    chk("pass_pass", {31'h0, test_pass}, 32'h1);

    // Failing verdict (test 3), then sticky against a later pass write
    pulse_rst();
    chk("rst2_done", {31'h0, test_done}, 32'h0);
    access(2'd1, 12'h51E, 32'h7, 1'b0);
    chk("fail_tohost", tohost, 32'h7);
    chk("fail_done", {31'h0, test_done}, 32'h1);
    chk("fail_pass", {31'h0, test_pass}, 32'h0);
    access(2'd1, 12'h51E, 32'h1, 1'b0);
    chk("sticky_rdata", csr_rdata, 32'h7);
    chk("sticky_tohost", tohost, 32'h1);
    chk("sticky_pass", {31'h0, test_pass}, 32'h0);
    chk("sticky_done", {31'h0, test_done}, 32'h1);

    // Set / clear / zero-mask set
    pulse_rst();
    access(2'd2, 12'h51E, 32'h10, 1'b0);
    chk("rs_tohost", tohost, 32'h10);
    chk("rs_rdata", csr_rdata, 32'h0);
    chk("rs_done", {31'h0, test_done}, 32'h0);
    access(2'd3, 12'h51E, 32'h10, 1'b0);
    chk("rc_tohost", tohost, 32'h0);
    chk("rc_rdata", csr_rdata, 32'h10);
    access(2'd1, 12'h51E, 32'hA4, 1'b0);
    access(2'd3, 12'h51E, 32'h0, 1'b0);
    chk("rc0_tohost", tohost, 32'hA4);
    chk("rc0_rdata", csr_rdata, 32'hA4);
    access(2'd2, 12'h51E, 32'h0, 1'b0);
    chk("rs0_ill", {31'h0, csr_illegal}, 32'h0);
    chk("rs0_tohost", tohost, 32'hA4);

    // Stalled access and op=0 are no-ops
    access(2'd1, 12'h51E, 32'h5, 1'b1);
    chk("stall_rvalid", {31'h0, csr_rvalid}, 32'h0);
    chk("stall_tohost", tohost, 32'hA4);
    access(2'd0, 12'h51E, 32'h5, 1'b0);
    chk("opnone_rvalid", {31'h0, csr_rvalid}, 32'h0);
    chk("opnone_tohost", tohost, 32'hA4);

    // instret: four retire pulses, the third stalled
    pulse_rst();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      instr_retire = 1'b1;
      stall = (i == 2);
    end
    @(negedge clk);
    instr_retire = 1'b0;
    stall = 1'b0;
    access(2'd2, 12'hC02, 32'h0, 1'b0);
    chk("instret_rd", csr_rdata, CNT ? 32'd3 : 32'd0);
    chk("instret_ill", {31'h0, csr_illegal}, 32'h0);
    access(2'd2, 12'hC82, 32'h0, 1'b0);
    chk("instreth_rd", csr_rdata, 32'h0);
    access(2'd3, 12'hC02, 32'h1, 1'b0);
    chk("instret_wr_ill", {31'h0, csr_illegal}, 32'h1);
    chk("instret_wr_old", csr_rdata, CNT ? 32'd3 : 32'd0);

    // Asynchronous reset between edges
    access(2'd1, 12'h51E, 32'h3, 1'b0);
    chk("pre_async_tohost", tohost, 32'h3);
    chk("pre_async_rvalid", {31'h0, csr_rvalid}, 32'h1);
    chk("pre_async_done", {31'h0, test_done}, 32'h1);
    chk("pre_async_pass", {31'h0, test_pass}, 32'h0);
    #2 rst = 1'b1;
    #1;
    chk("async_tohost", tohost, 32'h0);
    chk("async_done", {31'h0, test_done}, 32'h0);
    chk("async_rvalid", {31'h0, csr_rvalid}, 32'h0);
    chk("async_rdata", csr_rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
